// File: rtl/uart_wishbone_bridge.sv
// Byte-stream to Wishbone classic master bridge: CMD/LEN/ADDR[/DATA] frames, bursts of 1..256 words.
// Optional ack timeout is enabled by defining UART_WISHBONE_BRIDGE_TIMEOUT_EN.
module uart_wishbone_bridge #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 4,
  parameter int WB_ADDR_W  = 30,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [WB_ADDR_W-1:0]    wb_adr,
  output logic [8*DATA_BYTES-1:0] wb_dat_w,
  output logic [DATA_BYTES-1:0]   wb_sel,
  input  logic [8*DATA_BYTES-1:0] wb_dat_r,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  output logic                    busy
);

  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [2:0] {
    S_CMD, S_LEN, S_ADDR, S_WDATA, S_WB_WR, S_WB_RD, S_TX_DATA
  } state_t;

  state_t         state, state_nxt;
  logic           is_wr, is_incr;
  logic [8:0]     word_cnt;
  logic [3:0]     byte_cnt;
  logic           bus_act;
  logic [DW-1:0]  rd_buf;
  logic           rx_fire, tx_fire, term, term_err, timeout;
  logic           cmd_ok, addr_last, data_last;

  assign rx_ready  = (state == S_CMD) || (state == S_LEN) || (state == S_ADDR) || (state == S_WDATA);
  assign tx_valid  = (state == S_TX_DATA);
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign tx_data   = rd_buf[DW-1 -: 8];
  assign busy      = (state != S_CMD);

  assign wb_cyc    = bus_act;
  assign wb_stb    = bus_act;
  assign wb_we     = bus_act && (state == S_WB_WR);
  assign wb_sel    = {DATA_BYTES{bus_act}};

  // err wins over ack; a timeout is indistinguishable from a bus error
  assign term      = bus_act && (wb_ack || wb_err || timeout);
  assign term_err  = wb_err || timeout;

  assign cmd_ok    = (rx_data >= 8'h01) && (rx_data <= 8'h04);
  assign addr_last = (byte_cnt == 4'(ADDR_BYTES - 1));
  assign data_last = (byte_cnt == 4'(DATA_BYTES - 1));

`ifdef UART_WISHBONE_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (!bus_act)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = bus_act && (to_cnt == TO_W'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_CMD;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CMD:     if (rx_fire && cmd_ok) state_nxt = S_LEN;
      S_LEN:     if (rx_fire) state_nxt = S_ADDR;
      S_ADDR:    if (rx_fire && addr_last) state_nxt = is_wr ? S_WDATA : S_WB_RD;
      S_WDATA:   if (rx_fire && data_last) state_nxt = S_WB_WR;
      S_WB_WR:   if (term) state_nxt = (word_cnt == 9'd1) ? S_CMD : S_WDATA;
      S_WB_RD:   if (term) state_nxt = S_TX_DATA;
      S_TX_DATA: if (tx_fire && data_last) state_nxt = (word_cnt == 9'd0) ? S_CMD : S_WB_RD;
      default:   state_nxt = S_CMD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr    <= 1'b0;
      is_incr  <= 1'b0;
      word_cnt <= '0;
      byte_cnt <= '0;
      bus_act  <= 1'b0;
      wb_adr   <= '0;
      wb_dat_w <= '0;
      rd_buf   <= '0;
    end else begin
      case (state)
        S_CMD: begin
          if (rx_fire && cmd_ok) begin
            is_wr   <= (rx_data == 8'h01) || (rx_data == 8'h03);
            is_incr <= (rx_data == 8'h01) || (rx_data == 8'h02);
          end
        end
        S_LEN: begin
          if (rx_fire) begin
            word_cnt <= {(rx_data == 8'h00), rx_data};
            wb_adr   <= '0;
            byte_cnt <= '0;
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            wb_adr   <= (wb_adr << 8) | WB_ADDR_W'(rx_data);
            byte_cnt <= addr_last ? 4'd0 : byte_cnt + 4'd1;
          end
        end
        S_WDATA: begin
          if (rx_fire) begin
            wb_dat_w <= (wb_dat_w << 8) | DW'(rx_data);
            byte_cnt <= data_last ? 4'd0 : byte_cnt + 4'd1;
          end
        end
        S_WB_WR, S_WB_RD: begin
          // strobe rises the cycle after entry and falls on the terminating edge
          bus_act <= bus_act ? !term : 1'b1;
          if (term) begin
            word_cnt <= word_cnt - 9'd1;
            if (is_incr)
              wb_adr <= wb_adr + 1'b1;
            if (state == S_WB_RD)
              rd_buf <= term_err ? '1 : wb_dat_r;
          end
        end
        S_TX_DATA: begin
          if (tx_fire) begin
            rd_buf   <= rd_buf << 8;
            byte_cnt <= data_last ? 4'd0 : byte_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
